// File: rtl/ber_sim_core.sv
// PAM4 BER emulator: PRBS31 source, optional 1/(1+D) precoding, 1+ALPHA*D ISI channel with
// table-driven noise, 1-tap DFE slicer and pre/post-FEC error counters.
// Build option: define BER_COUNTER_SAT_EN to make all status counters saturate instead of wrap.
module ber_sim_core #(
  parameter int  SYMBOL_SEPARATION = 48,
  parameter int  SIGNAL_RESOLUTION = 8,
  parameter real ALPHA             = 0.5,
  parameter int  FRAME_BITS        = 4096,
  parameter int  T_PER_ITER        = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [31:0] probability_idx,
  input  logic [63:0] probability_in,
  input  logic        precode_en,
  input  logic [4:0]  max_iterations_2d,
  output logic [63:0] total_bits,
  output logic [63:0] total_bit_errors_pre,
  output logic [63:0] total_bit_errors_post,
  output logic [63:0] total_frames,
  output logic [63:0] total_frame_errors
);

  localparam int SR  = SIGNAL_RESOLUTION;
  localparam int RW  = SIGNAL_RESOLUTION + 3;
  localparam int PW  = SIGNAL_RESOLUTION + 11;
  localparam int A_Q = $rtoi(ALPHA * 256.0 + 0.5);
  localparam int FW  = $clog2(FRAME_BITS + 1);

  // Slicer thresholds compared against 2*e so that odd separations stay exact.
  localparam logic signed [RW:0] TH0 = (RW+1)'(SYMBOL_SEPARATION);
  localparam logic signed [RW:0] TH1 = (RW+1)'(3 * SYMBOL_SEPARATION);
  localparam logic signed [RW:0] TH2 = (RW+1)'(5 * SYMBOL_SEPARATION);

  function automatic logic [SR-1:0] level(input logic [1:0] q);
    return SR'(32'(q) * 32'(SYMBOL_SEPARATION));
  endfunction

  function automatic logic signed [RW-1:0] tap(input logic [SR-1:0] lvl);
    logic [PW-1:0] prod;
    prod = PW'(A_Q) * PW'(lvl);
    return signed'(RW'(prod >> 8));
  endfunction

  function automatic logic [63:0] acc_add(input logic [63:0] a, input logic [63:0] b);
`ifdef BER_COUNTER_SAT_EN
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[64] ? '1 : sum[63:0];
`else
    return a + b;
`endif
  endfunction

  // Noise table: no reset, written on every edge regardless of rstn/en.
  logic [63:0] r_table [64];

  always_ff @(posedge clk) begin
    if (probability_idx < 32'd64) r_table[probability_idx[5:0]] <= probability_in;
  end

  // ---------------- Stage 1: source, precode, noise draw ----------------
  logic [30:0]          r_lfsr;
  logic [63:0]          r_rng;
  logic [1:0]           r_p_prev;
  logic [SR-1:0]        r_x1;
  logic signed [RW-1:0] r_nz1;
  logic [1:0]           r_ref1;
  logic                 r_v1;

  logic [30:0]          w_lfsr_a, w_lfsr_b;
  logic                 w_b1, w_b0;
  logic [1:0]           w_s, w_p;
  logic [63:0]          w_rx1, w_rx2, w_rng_next;
  logic [6:0]           w_k;
  logic signed [RW-1:0] w_kx, w_noise;

  always_comb begin
    w_lfsr_a   = {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
    w_lfsr_b   = {w_lfsr_a[29:0], w_lfsr_a[30] ^ w_lfsr_a[27]};
    w_b1       = w_lfsr_a[0];
    w_b0       = w_lfsr_b[0];
    w_s        = {w_b1, w_b1 ^ w_b0};
    w_p        = precode_en ? (w_s - r_p_prev) : w_s;
    w_rx1      = r_rng ^ (r_rng << 13);
    w_rx2      = w_rx1 ^ (w_rx1 >> 7);
    w_rng_next = w_rx2 ^ (w_rx2 << 17);
  end

  always_comb begin
    w_k = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (r_rng > r_table[i]) w_k = w_k + 7'd1;
    end
    w_kx    = signed'(RW'(w_k));
    w_noise = r_rng[63] ? -w_kx : w_kx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr   <= 31'd1;
      r_rng    <= 64'h0123_4567_89AB_CDEF;
      r_p_prev <= '0;
      r_x1     <= '0;
      r_nz1    <= '0;
      r_ref1   <= '0;
      r_v1     <= 1'b0;
    end else if (en) begin
      r_lfsr   <= w_lfsr_b;
      r_rng    <= w_rng_next;
      r_p_prev <= w_p;
      r_x1     <= level(w_p);
      r_nz1    <= w_noise;
      r_ref1   <= {w_b1, w_b0};
      r_v1     <= 1'b1;
    end
  end

  // ---------------- Stage 2: ISI channel, DFE, slicer ----------------
  logic [SR-1:0]        r_xprev, r_dlvl;
  logic [1:0]           r_q2;
  logic [1:0]           r_ref2;
  logic                 r_v2;

  logic signed [RW-1:0] w_r, w_e;
  logic signed [RW:0]   w_e2;
  logic [1:0]           w_q;

  always_comb begin
    w_r  = signed'(RW'(r_x1)) + tap(r_xprev) + r_nz1;
    w_e  = w_r - tap(r_dlvl);
    w_e2 = {w_e, 1'b0};
    if (w_e2 >= TH2)      w_q = 2'd3;
    else if (w_e2 >= TH1) w_q = 2'd2;
    else if (w_e2 >= TH0) w_q = 2'd1;
    else                  w_q = 2'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_xprev <= '0;
      r_dlvl  <= '0;
      r_q2    <= '0;
      r_ref2  <= '0;
      r_v2    <= 1'b0;
    end else if (en) begin
      if (r_v1) begin
        r_xprev <= r_x1;
        r_dlvl  <= level(w_q);
      end
      r_q2   <= w_q;
      r_ref2 <= r_ref1;
      r_v2   <= r_v1;
    end
  end

  // ---------------- Stage 3: decode, compare, frame FEC model ----------------
  logic [1:0]    r_qprev;
  logic [FW-1:0] r_fbits, r_acc;
  logic [63:0]   r_bits, r_pre, r_post, r_frames, r_ferr;

  logic [1:0]    w_shat, w_rxb, w_diff, w_pc;
  logic [FW-1:0] w_fb_inc, w_acc;
  logic [31:0]   w_limit;
  logic          w_fend, w_ffail;

  always_comb begin
    w_shat   = precode_en ? (r_q2 + r_qprev) : r_q2;
    w_rxb    = {w_shat[1], w_shat[1] ^ w_shat[0]};
    w_diff   = w_rxb ^ r_ref2;
    w_pc     = {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
    w_fb_inc = r_fbits + FW'(2);
    w_acc    = r_acc + FW'(w_pc);
    w_limit  = 32'(T_PER_ITER) * 32'(max_iterations_2d);
    w_fend   = (w_fb_inc == FW'(FRAME_BITS));
    w_ffail  = w_fend && (32'(w_acc) > w_limit);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_qprev  <= '0;
      r_fbits  <= '0;
      r_acc    <= '0;
      r_bits   <= '0;
      r_pre    <= '0;
      r_post   <= '0;
      r_frames <= '0;
      r_ferr   <= '0;
    end else if (en && r_v2) begin
      r_qprev <= r_q2;
      r_fbits <= w_fend ? '0 : w_fb_inc;
      r_acc   <= w_fend ? '0 : w_acc;
      r_bits  <= acc_add(r_bits, 64'd2);
      r_pre   <= acc_add(r_pre, 64'(w_pc));
      if (w_fend) r_frames <= acc_add(r_frames, 64'd1);
      if (w_ffail) begin
        r_post <= acc_add(r_post, 64'(w_acc));
        r_ferr <= acc_add(r_ferr, 64'd1);
      end
    end
  end

  assign total_bits            = r_bits;
  assign total_bit_errors_pre  = r_pre;
  assign total_bit_errors_post = r_post;
  assign total_frames          = r_frames;
  assign total_frame_errors    = r_ferr;

endmodule

// File: tb/tb_ber_sim_core.sv
// Scoreboard bench for ber_sim_core: symbol-level reference model feeds an expectation queue,
// a negedge monitor compares the five status counters against it.
module tb_ber_sim_core;

  localparam int S  = 48;
  localparam int FB = 4096;
  localparam int TP = 8;
  localparam int AQ = 128;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] probability_idx = '1;
  logic [63:0] probability_in = '0;
  logic        precode_en = 1'b1;
  logic [4:0]  max_iterations_2d = 5'd3;
  logic [63:0] total_bits, total_bit_errors_pre, total_bit_errors_post;
  logic [63:0] total_frames, total_frame_errors;

  always #5 clk = ~clk;

  ber_sim_core dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .en                    (en),
    .probability_idx       (probability_idx),
    .probability_in        (probability_in),
    .precode_en            (precode_en),
    .max_iterations_2d     (max_iterations_2d),
    .total_bits            (total_bits),
    .total_bit_errors_pre  (total_bit_errors_pre),
    .total_bit_errors_post (total_bit_errors_post),
    .total_frames          (total_frames),
    .total_frame_errors    (total_frame_errors)
  );

  typedef struct {
    string       name;
    logic [63:0] b, pre, post, fr, fe;
  } exp_t;
  typedef struct {
    int q;
    int refb;
  } sym_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          bitq[$];
  logic [63:0] rng;
  logic [63:0] tbl [64];
  int          p_prev, x_prev, d_prev, q_prev, fbits, acc;
  sym_t        pend[$];
  logic [63:0] m_bits, m_pre, m_post, m_fr, m_fe;

  function automatic void push_exp(string nm, logic [63:0] b, logic [63:0] pre,
                                   logic [63:0] post, logic [63:0] fr, logic [63:0] fe);
    exp_t e;
    e.name = nm; e.b = b; e.pre = pre; e.post = post; e.fr = fr; e.fe = fe;
    expq.push_back(e);
  endfunction

  function automatic void push_model(string nm);
    push_exp(nm, m_bits, m_pre, m_post, m_fr, m_fe);
  endfunction

  function automatic void model_reset();
    bitq.delete();
    for (int i = 0; i < 31; i++) bitq.push_back(i == 30);
    rng = 64'h0123_4567_89AB_CDEF;
    p_prev = 0; x_prev = 0; d_prev = 0; q_prev = 0; fbits = 0; acc = 0;
    pend.delete();
    m_bits = 0; m_pre = 0; m_post = 0; m_fr = 0; m_fe = 0;
  endfunction

  // Bit history a[t] = a[t-31] ^ a[t-28]
  function automatic int next_bit();
    bit nb;
    nb = bitq[0] ^ bitq[3];
    void'(bitq.pop_front());
    bitq.push_back(nb);
    return int'(nb);
  endfunction

  function automatic int gray(int v);
    case (v)
      0: return 0;
      1: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ungray(int s);
    case (s)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int tap(int v);
    return (AQ * v) / 256;
  endfunction

  function automatic logic [63:0] xs(logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 7);
    return t ^ (t << 17);
  endfunction

  function automatic void decode(sym_t sy);
    int shat, err;
    logic [1:0] d;
    shat = precode_en ? (sy.q + q_prev) % 4 : sy.q;
    q_prev = sy.q;
    d = 2'(ungray(shat) ^ sy.refb);
    err = $countones(d);
    m_bits += 2; m_pre += 64'(err);
    fbits += 2; acc += err;
    if (fbits == FB) begin
      m_fr += 1;
      if (acc > TP * int'(max_iterations_2d)) begin
        m_post += 64'(acc);
        m_fe += 1;
      end
      fbits = 0; acc = 0;
      push_model("frame_end");
    end
  endfunction

  function automatic void model_step();
    int b1, b0, s, p, x, k, nz, r, e, q;
    logic [63:0] u;
    sym_t sy;
    b1 = next_bit();
    b0 = next_bit();
    s = gray(b1 * 2 + b0);
    p = precode_en ? (s - p_prev + 4) % 4 : s;
    p_prev = p;
    x = p * S;
    u = rng;
    rng = xs(rng);
    k = 0;
    for (int i = 0; i < 64; i++) if (u > tbl[i]) k++;
    nz = u[63] ? -k : k;
    r = x + tap(x_prev) + nz;
    e = r - tap(d_prev);
    q = (e < 0) ? 0 : (2 * e + S) / (2 * S);
    if (q > 3) q = 3;
    x_prev = x;
    d_prev = q * S;
    sy.q = q; sy.refb = b1 * 2 + b0;
    pend.push_back(sy);
    if (pend.size() == 3) decode(pend.pop_front());
  endfunction

  function automatic void chk(string nm, string fld, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %0d required %0d", nm, fld, got, want);
    end
  endfunction

  // Monitor: compares every queued expectation against the live counters
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      chk(e.name, "bits", total_bits, e.b);
      chk(e.name, "pre", total_bit_errors_pre, e.pre);
      chk(e.name, "post", total_bit_errors_post, e.post);
      chk(e.name, "frames", total_frames, e.fr);
      chk(e.name, "frame_errors", total_frame_errors, e.fe);
    end
  end

  task automatic wr(logic [31:0] idx, logic [63:0] v);
    @(negedge clk);
    en = 1'b0;
    probability_idx = idx;
    probability_in = v;
    @(posedge clk);
    if (idx < 32'd64) tbl[idx[5:0]] = v;
  endtask

  task automatic wr_done();
    @(negedge clk);
    probability_idx = '1;
  endtask

  task automatic fill(int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0: wr(32'(i), '1);
        1: wr(32'(i), '0);
        2: wr(32'(i), {4'hF, 28'($urandom), 32'($urandom)});
        default: wr(32'(i), {8'hFF, 24'($urandom), 32'($urandom)});
      endcase
    end
    wr_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    push_exp("reset", '0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run(int n, bit gaps);
    int done = 0;
    while (done < n) begin
      @(negedge clk);
      en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      if (en) begin
        model_step();
        done++;
        if (done % 512 == 0) push_model("periodic");
      end
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    model_reset();
    // All-ones table: k=0 every symbol, loaded while held in reset
    fill(0);
    precode_en = 1'b1;
    max_iterations_2d = 5'd3;
    do_reset();
    run(10002, 1'b0);
    push_exp("clean_10002", 64'd20000, 0, 0, 64'd4, 0);

    // Out-of-range addresses must not touch the table
    wr(32'hFFFF_FFFF, '0);
    wr(32'd64 + 32'($urandom_range(0, 1000)), '0);
    wr_done();
    do_reset();
    run(1000, 1'b0);
    push_exp("bad_idx_1000", 64'd1996, 0, 0, 0, 0);

    // Hold with en=0, then asynchronous reset between edges
    run(300, 1'b1);
    push_model("pre_hold");
    repeat (50) @(posedge clk);
    @(negedge clk);
    push_model("hold_50");
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    push_exp("async_reset", '0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run(1000, 1'b0);
    push_exp("after_reset_1000", 64'd1996, 0, 0, 0, 0);

    // No precoding, zero noise, random enable gaps
    precode_en = 1'b0;
    do_reset();
    run(2000, 1'b1);
    push_exp("noprecode_2000", 64'd3996, 0, 0, 0, 0);

    // All-zero table: k=64 every symbol, every frame uncorrectable
    fill(1);
    precode_en = 1'b1;
    max_iterations_2d = 5'd3;
    do_reset();
    run(4098, 1'b0);
    push_exp("max_noise_4098", 64'd8192, m_pre, m_pre, 64'd2, 64'd2);

    // Moderately noisy random table, no correction budget
    fill(2);
    precode_en = 1'($urandom_range(0, 1));
    max_iterations_2d = 5'd0;
    do_reset();
    run(6150, 1'b1);
    push_model("noisy_it0");

    // Light random noise, full correction budget
    fill(3);
    precode_en = 1'($urandom_range(0, 1));
    max_iterations_2d = 5'd31;
    do_reset();
    run(6150, 1'b1);
    push_model("light_it31");

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
